// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel stage.
// Takes raster-order 8-bit pixels and buffers two lines internally.
// For every interior pixel it emits registered |Gx|>>2 and |Gy|>>2 plus the sign bits.
// Pipeline: the accepting edge shifts the window; the next edge registers the gradients.
module sobel_gradient #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       in_valid,
    input  logic [7:0] pixel,
    output logic       out_valid,
    output logic [7:0] gx,
    output logic [7:0] gy,
    output logic       gx_neg,
    output logic       gy_neg,
    output logic       frame_done
);

    localparam int unsigned CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int unsigned RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;

    typedef enum logic {
        StFill,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;

    // Window: [column 0=oldest..2=newest][row 0=top..2=bottom]
    logic [2:0][2:0][7:0] win_q, win_d;
    logic                 win_valid_q, win_valid_d;
    logic                 win_last_q, win_last_d;

    // lb1 holds row r-1 and lb2 holds row r-2, both indexed by column
    logic [7:0] lb1_q [IMG_W];
    logic [7:0] lb2_q [IMG_W];

    logic       out_valid_q, out_valid_d;
    logic       frame_done_q, frame_done_d;
    logic [7:0] gx_q, gx_d, gy_q, gy_d;
    logic       gx_neg_q, gx_neg_d, gy_neg_q, gy_neg_d;

    logic [10:0] gx_s, gy_s, gx_mag, gy_mag;

    // Weighted 1-2-1 sum of three pixels; max 1020 fits in 11 bits
    function automatic logic [10:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    // Raster counters, FILL/RUN state and window shift on accepted pixels
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        state_d     = state_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
        if (in_valid) begin
            win_d[0]    = win_q[1];
            win_d[1]    = win_q[2];
            win_d[2][0] = lb2_q[col_q];
            win_d[2][1] = lb1_q[col_q];
            win_d[2][2] = pixel;
            // A full window exists only once three columns of this row have arrived
            win_valid_d = (state_q == StRun) && (col_q >= CW'(2));
            win_last_d  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                if (row_q == RW'(IMG_H - 1)) begin
                    row_d   = '0;
                    state_d = StFill;
                end else begin
                    row_d = row_q + 1'b1;
                    if (row_q == RW'(1)) begin
                        state_d = StRun;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Signed gradients from the stored window, then magnitude and sign
    always_comb begin
        gx_s   = wsum(win_q[2][0], win_q[2][1], win_q[2][2])
               - wsum(win_q[0][0], win_q[0][1], win_q[0][2]);
        gy_s   = wsum(win_q[0][2], win_q[1][2], win_q[2][2])
               - wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
        gx_mag = gx_s[10] ? (~gx_s + 11'd1) : gx_s;
        gy_mag = gy_s[10] ? (~gy_s + 11'd1) : gy_s;
    end

    // Output register next-state; data holds when no new window
    always_comb begin
        out_valid_d  = win_valid_q;
        frame_done_d = win_valid_q & win_last_q;
        gx_d         = gx_q;
        gy_d         = gy_q;
        gx_neg_d     = gx_neg_q;
        gy_neg_d     = gy_neg_q;
        if (win_valid_q) begin
            gx_d     = gx_mag[9:2];
            gy_d     = gy_mag[9:2];
            gx_neg_d = gx_s[10];
            gy_neg_d = gy_s[10];
        end
    end

    // Control, window and output state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StFill;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            gx_neg_q     <= 1'b0;
            gy_neg_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            gx_neg_q     <= gx_neg_d;
            gy_neg_q     <= gy_neg_d;
        end
    end

    // Line buffers need no reset: rows 0 and 1 of every frame overwrite them before use
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= pixel;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign gx         = gx_q;
    assign gy         = gy_q;
    assign gx_neg     = gx_neg_q;
    assign gy_neg     = gy_neg_q;

endmodule

// File: tb/tb_sobel_gradient.sv
// Scoreboard bench for sobel_gradient.
// The driver keeps a full image array and computes each expected gradient directly from the
// Sobel formulas. The monitor pops and compares whenever out_valid is high.
module tb_sobel_gradient;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] pixel = '0;
    logic       out_valid, frame_done, gx_neg, gy_neg;
    logic [7:0] gx, gy;

    sobel_gradient #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .pixel     (pixel),
        .out_valid (out_valid),
        .gx        (gx),
        .gy        (gy),
        .gx_neg    (gx_neg),
        .gy_neg    (gy_neg),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         acc;
        logic [7:0] gx;
        logic [7:0] gy;
        logic       gxn;
        logic       gyn;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    int img[H][W];
    int mr = 0;
    int mc = 0;

    function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
        case (kind)
            0: return 8'd100;
            1: return (c < 4) ? 8'd0 : 8'd255;
            2: return (c < 4) ? 8'd255 : 8'd0;
            3: return (r < 4) ? 8'd0 : 8'd255;
            4: return 8'(10 * c);
            6: return 8'd50;
            default: return 8'($urandom_range(255));
        endcase
    endfunction

    // Present one pixel for one cycle and record any window it completes
    task automatic accept_pixel(input logic [7:0] p);
        exp_t e;
        int   sx, sy;
        in_valid = 1'b1;
        pixel = p;
        img[mr][mc] = int'(p);
        if (mr >= 2 && mc >= 2) begin
            sx = (img[mr-2][mc] + 2 * img[mr-1][mc] + img[mr][mc])
               - (img[mr-2][mc-2] + 2 * img[mr-1][mc-2] + img[mr][mc-2]);
            sy = (img[mr][mc-2] + 2 * img[mr][mc-1] + img[mr][mc])
               - (img[mr-2][mc-2] + 2 * img[mr-2][mc-1] + img[mr-2][mc]);
            e.acc  = cyc + 1;
            e.gxn  = (sx < 0);
            e.gyn  = (sy < 0);
            e.gx   = 8'(((sx < 0) ? -sx : sx) / 4);
            e.gy   = 8'(((sy < 0) ? -sy : sy) / 4);
            e.last = (mr == H - 1) && (mc == W - 1);
            sb.push_back(e);
        end
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        pixel = 8'($urandom_range(255));
        @(posedge clk);
        #1;
    endtask

    task automatic run_pixels(input int kind, input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) idle();
            accept_pixel(pix_of(kind, mr, mc));
        end
    endtask

    // Monitor: compare on out_valid, check hold/reset values otherwise
    logic [7:0] last_gx = '0;
    logic [7:0] last_gy = '0;
    logic       last_gxn = 1'b0;
    logic       last_gyn = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                checks++;
                if (out_valid || frame_done || gx != 0 || gy != 0 || gx_neg || gy_neg) begin
                    failures++;
                    $display("FAIL reset_state: ov=%0b fd=%0b gx=%0d gy=%0d sx=%0b sy=%0b want all 0",
                             out_valid, frame_done, gx, gy, gx_neg, gy_neg);
                end
                last_gx = '0;
                last_gy = '0;
                last_gxn = 1'b0;
                last_gyn = 1'b0;
            end else if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got gx=%0d gy=%0d at cycle %0d, want none",
                             gx, gy, cyc);
                end else begin
                    e = sb.pop_front();
                    if (gx != e.gx || gy != e.gy || gx_neg != e.gxn || gy_neg != e.gyn ||
                        frame_done != e.last || cyc != e.acc + 1) begin
                        failures++;
                        $display({"FAIL output: got gx=%0d gy=%0d sx=%0b sy=%0b fd=%0b cyc=%0d, ",
                                  "want gx=%0d gy=%0d sx=%0b sy=%0b fd=%0b cyc=%0d"},
                                 gx, gy, gx_neg, gy_neg, frame_done, cyc,
                                 e.gx, e.gy, e.gxn, e.gyn, e.last, e.acc + 1);
                    end
                    last_gx = e.gx;
                    last_gy = e.gy;
                    last_gxn = e.gxn;
                    last_gyn = e.gyn;
                end
            end else begin
                checks++;
                if (frame_done || gx != last_gx || gy != last_gy || gx_neg != last_gxn ||
                    gy_neg != last_gyn) begin
                    failures++;
                    $display("FAIL hold: got gx=%0d gy=%0d sx=%0b sy=%0b fd=%0b, want %0d %0d %0b %0b 0",
                             gx, gy, gx_neg, gy_neg, frame_done,
                             last_gx, last_gy, last_gxn, last_gyn);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        run_pixels(0, W * H, 0);   // flat
        run_pixels(1, W * H, 0);   // vertical edge
        run_pixels(2, W * H, 0);   // mirrored vertical edge
        run_pixels(3, W * H, 0);   // horizontal edge
        run_pixels(4, W * H, 0);   // ramp
        run_pixels(4, W * H, 50);  // ramp with gaps
        run_pixels(5, W * H, 30);  // random with gaps
        run_pixels(5, W * H, 0);   // random continuous
        repeat (3) idle();

        // Reset partway into row 4, right after an output was launched
        run_pixels(5, 4 * W + 4, 20);
        n_rst = 1'b0;
        #1;
        checks++;
        if (out_valid || frame_done || gx != 0 || gy != 0 || gx_neg || gy_neg) begin
            failures++;
            $display("FAIL async_reset_clear: ov=%0b fd=%0b gx=%0d gy=%0d, want all 0",
                     out_valid, frame_done, gx, gy);
        end
        sb.delete();
        mr = 0;
        mc = 0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        run_pixels(6, W * H, 0);   // flat 50 frame
        run_pixels(1, W * H, 0);   // back-to-back vertical edge frame
        run_pixels(5, W * H, 0);   // back-to-back random frame
        repeat (5) idle();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_outputs: pending=%0d, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
